// File: rtl/bowling_score_unit.sv
// bowling_score_unit: one-player ten-pin scorekeeper tracking frame, throw and running score.
// Define BOWLING_BONUS_EN for strike/spare bonus scoring; otherwise score is the plain pin sum.
module bowling_score_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] N,
    input  logic       APD,
    input  logic       upd,
    input  logic       LF,
    output logic [9:0] score,
    output logic       done,
    output logic       FT,
    output logic       NF,
    output logic       AD
);
    localparam int unsigned PIN_W   = 4;
    localparam int unsigned SCORE_W = 10;
    localparam int unsigned FRAME_W = 4;
    localparam logic [PIN_W-1:0]   ALL_PINS   = PIN_W'(10);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(10);
`ifdef BOWLING_BONUS_EN
    localparam int unsigned BONUS_W = 2;
`endif

    typedef enum logic [1:0] {THROW1, THROW2, THROW3} throw_t;

    throw_t               state, state_n;
    logic                 upd_d;
    logic [FRAME_W-1:0]   frame, frame_n;
    logic [PIN_W-1:0]     rack, rack_n;       // pins already down in the current rack
    logic                 second, second_n;   // next ball is the second of its rack
    logic                 tenth, tenth_n;     // current frame plays under tenth-frame rules
    logic [SCORE_W-1:0]   score_n;
    logic                 done_n, ft_n, nf_n, ad_n;
`ifdef BOWLING_BONUS_EN
    logic [BONUS_W-1:0]   b1, b1_n, b2, b2_n;
    logic                 spare;
`endif

    logic                 accept, tenth_now, all_down, strike;
    logic                 frame_end, game_end;
    logic [PIN_W-1:0]     n_lim, avail, pins;
    logic [SCORE_W-1:0]   add;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= THROW1;
            upd_d  <= 1'b0;
            frame  <= FRAME_W'(1);
            rack   <= '0;
            second <= 1'b0;
            tenth  <= 1'b0;
            score  <= '0;
            done   <= 1'b0;
            FT     <= 1'b1;
            NF     <= 1'b0;
            AD     <= 1'b0;
`ifdef BOWLING_BONUS_EN
            b1     <= '0;
            b2     <= '0;
`endif
        end else begin
            state  <= state_n;
            upd_d  <= upd;
            frame  <= frame_n;
            rack   <= rack_n;
            second <= second_n;
            tenth  <= tenth_n;
            score  <= score_n;
            done   <= done_n;
            FT     <= ft_n;
            NF     <= nf_n;
            AD     <= ad_n;
`ifdef BOWLING_BONUS_EN
            b1     <= b1_n;
            b2     <= b2_n;
`endif
        end
    end

    // Throw acceptance, pin sanitising, scoring and frame sequencing
    always_comb begin
        state_n   = state;
        frame_n   = frame;
        rack_n    = rack;
        second_n  = second;
        tenth_n   = tenth;
        score_n   = score;
        done_n    = done;
        ft_n      = FT;
        nf_n      = 1'b0;
        frame_end = 1'b0;
        game_end  = 1'b0;

        accept    = upd && !upd_d && !done;
        ad_n      = accept;
        tenth_now = (state == THROW1) ? ((frame == LAST_FRAME) || LF) : tenth;

        n_lim    = (N > ALL_PINS) ? ALL_PINS : N;
        avail    = ALL_PINS - rack;
        pins     = (n_lim > avail) ? avail : n_lim;
        all_down = ((rack + pins) == ALL_PINS) || APD;
        strike   = all_down && !second;

        add = SCORE_W'(pins);
`ifdef BOWLING_BONUS_EN
        spare = all_down && second;
        b1_n  = b1;
        b2_n  = b2;
        if (b1 != '0) add = add + SCORE_W'(pins);
        if (b1 == BONUS_W'(2)) add = add + SCORE_W'(pins);
`endif

        if (accept) begin
            score_n = score + add;
            tenth_n = tenth_now;
`ifdef BOWLING_BONUS_EN
            // Tenth-rule frames score their extra balls at face value: no new bonus.
            b1_n = b2;
            b2_n = '0;
            if (!tenth_now && strike) begin
                b1_n = b2 + BONUS_W'(1);
                b2_n = BONUS_W'(1);
            end else if (!tenth_now && spare) begin
                b1_n = b2 + BONUS_W'(1);
            end
`endif
            case (state)
                THROW1: begin
                    if (!tenth_now && strike) begin
                        frame_end = 1'b1;
                    end else begin
                        state_n  = THROW2;
                        ft_n     = 1'b0;
                        rack_n   = strike ? '0 : pins;
                        second_n = !strike;
                    end
                end
                THROW2: begin
                    if (!tenth_now) begin
                        frame_end = 1'b1;
                    end else if (all_down) begin
                        state_n  = THROW3;
                        rack_n   = '0;
                        second_n = 1'b0;
                    end else if (!second) begin
                        state_n  = THROW3;
                        rack_n   = pins;
                        second_n = 1'b1;
                    end else begin
                        game_end = 1'b1;
                    end
                end
                default: game_end = 1'b1;
            endcase

            if (frame_end) begin
                frame_n  = frame + FRAME_W'(1);
                state_n  = THROW1;
                rack_n   = '0;
                second_n = 1'b0;
                ft_n     = 1'b1;
                nf_n     = 1'b1;
            end
            if (game_end) begin
                done_n   = 1'b1;
                state_n  = THROW1;
                rack_n   = '0;
                second_n = 1'b0;
                ft_n     = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bowling_score_unit.sv
// Self-checking bench for bowling_score_unit; expected per-throw results go through a scoreboard queue.
`timescale 1ns/1ps
module tb_bowling_score_unit;
    typedef struct packed {
        logic [9:0] score;
        logic       ft;
        logic       nf;
        logic       done;
    } exp_t;

`ifdef BOWLING_BONUS_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] N;
    logic       APD, upd, LF;
    logic [9:0] score;
    logic       done, FT, NF, AD;

    exp_t exp_q[$];
    int   tests;
    int   fails;

    bowling_score_unit dut (
        .clk  (clk),
        .reset(reset),
        .N    (N),
        .APD  (APD),
        .upd  (upd),
        .LF   (LF),
        .score(score),
        .done (done),
        .FT   (FT),
        .NF   (NF),
        .AD   (AD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pops one expectation per AD pulse and compares the registered outputs
    task automatic scoreboard_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (AD === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_ad: AD=1 with no throw pending (score=%0d done=%0b)", score, done);
                end else begin
                    e = exp_q.pop_front();
                    if ({score, FT, NF, done} !== {e.score, e.ft, e.nf, e.done}) begin
                        fails++;
                        $display("FAIL throw_result: got score=%0d FT=%0b NF=%0b done=%0b, want score=%0d FT=%0b NF=%0b done=%0b",
                                 score, FT, NF, done, e.score, e.ft, e.nf, e.done);
                    end
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; upd = 1'b0; APD = 1'b0; LF = 1'b0; N = 4'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic throw_pins(input logic [3:0] n, input logic lf, input logic apd,
                              input logic [9:0] s, input logic f, input logic nfe, input logic dn);
        exp_t e;
        e.score = s; e.ft = f; e.nf = nfe; e.done = dn;
        @(negedge clk);
        N = n; LF = lf; APD = apd; upd = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        upd = 1'b0; APD = 1'b0; LF = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (3) begin
            @(negedge clk);
            tests++;
            if ({score, FT, done, AD, NF} !== {10'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL reset_idle: got score=%0d FT=%0b done=%0b AD=%0b NF=%0b, want 0 1 0 0 0",
                         score, FT, done, AD, NF);
            end
        end
        // reset wins over a simultaneous throw
        @(negedge clk);
        reset = 1'b1; N = 4'd5; upd = 1'b1;
        @(negedge clk);
        reset = 1'b0; upd = 1'b0;
        @(negedge clk);
        tests++;
        if ({score, AD, FT} !== {10'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_priority: got score=%0d AD=%0b FT=%0b, want 0 0 1", score, AD, FT);
        end
    endtask

    task automatic test_game();
        int pin_t [17] = '{10,4,6,3,4,10,5,2,6,4,10,10,2,7,10,10,10};
        int sc_b  [17] = '{10,18,30,36,40,50,60,64,70,74,94,114,120,134,144,154,164};
        int sc_p  [17] = '{10,14,20,23,27,37,42,44,50,54,64,74,76,83,93,103,113};
        int nf_t  [17] = '{1,0,1,0,1,1,0,1,0,1,1,1,0,1,0,0,0};
        logic [9:0] fin;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            throw_pins(4'(pin_t[i]), 1'b0, 1'b0,
                       BONUS ? 10'(sc_b[i]) : 10'(sc_p[i]),
                       (nf_t[i] != 0) || (i == 16), nf_t[i] != 0, i == 16);
        end
        fin = BONUS ? 10'd164 : 10'd113;
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL game_drain: %0d throws without AD, want 0", exp_q.size());
            exp_q.delete();
        end
        tests++;
        if ({score, done} !== {fin, 1'b1}) begin
            fails++;
            $display("FAIL game_final: got score=%0d done=%0b, want score=%0d done=1", score, done, fin);
        end
    endtask

    task automatic test_perfect();
        logic [9:0] s;
        logic [9:0] fin;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            if (!BONUS)      s = 10'(10 * (i + 1));
            else if (i == 0) s = 10'd10;
            else if (i == 1) s = 10'd30;
            else if (i < 9)  s = 10'(60 + 30 * (i - 2));
            else if (i == 9) s = 10'd270;
            else if (i == 10) s = 10'd290;
            else             s = 10'd300;
            throw_pins(4'd10, 1'b0, 1'b0, s, (i < 9) || (i == 11), i < 9, i == 11);
        end
        fin = BONUS ? 10'd300 : 10'd120;
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL perfect_drain: %0d throws without AD, want 0", exp_q.size());
            exp_q.delete();
        end
        // throw after game over must be ignored
        @(negedge clk);
        N = 4'd10; upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        @(negedge clk);
        tests++;
        if ({score, done, FT} !== {fin, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL perfect_after_done: got score=%0d done=%0b FT=%0b, want score=%0d done=1 FT=1",
                     score, done, FT, fin);
        end
    endtask

    task automatic test_tenth_frame();
        apply_reset();
        throw_pins(4'd3, 1'b1, 1'b0, 10'd3, 1'b0, 1'b0, 1'b0);
        throw_pins(4'd4, 1'b0, 1'b0, 10'd7, 1'b1, 1'b0, 1'b1);
        apply_reset();
        throw_pins(4'd7, 1'b1, 1'b0, 10'd7,  1'b0, 1'b0, 1'b0);
        throw_pins(4'd3, 1'b0, 1'b0, 10'd10, 1'b0, 1'b0, 1'b0);
        throw_pins(4'd5, 1'b0, 1'b0, 10'd15, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL tenth_drain: %0d throws without AD, want 0", exp_q.size());
            exp_q.delete();
        end
        tests++;
        if ({score, done} !== {10'd15, 1'b1}) begin
            fails++;
            $display("FAIL tenth_final: got score=%0d done=%0b, want 15 1", score, done);
        end
    endtask

    task automatic test_held_upd();
        exp_t e;
        int   pulses;
        apply_reset();
        e.score = 10'd3; e.ft = 1'b0; e.nf = 1'b0; e.done = 1'b0;
        @(negedge clk);
        N = 4'd3; upd = 1'b1;
        exp_q.push_back(e);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (AD === 1'b1) pulses++;
        end
        upd = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (AD === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL held_upd_ad_count: got %0d AD pulses, want 1", pulses);
        end
        tests++;
        if (score !== 10'd3) begin
            fails++;
            $display("FAIL held_upd_score: got %0d, want 3", score);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL held_drain: %0d throws without AD, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_sanitise_and_reset();
        apply_reset();
        throw_pins(4'd15, 1'b0, 1'b0, 10'd10, 1'b1, 1'b1, 1'b0);
        throw_pins(4'd6,  1'b0, 1'b0, BONUS ? 10'd22 : 10'd16, 1'b0, 1'b0, 1'b0);
        throw_pins(4'd9,  1'b0, 1'b0, BONUS ? 10'd30 : 10'd20, 1'b1, 1'b1, 1'b0);
        throw_pins(4'd5,  1'b0, 1'b0, BONUS ? 10'd40 : 10'd25, 1'b0, 1'b0, 1'b0);
        // mid-frame reset
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({score, FT, done, AD, NF} !== {10'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL midframe_reset: got score=%0d FT=%0b done=%0b AD=%0b NF=%0b, want 0 1 0 0 0",
                     score, FT, done, AD, NF);
        end
        throw_pins(4'd2, 1'b0, 1'b0, 10'd2,  1'b0, 1'b0, 1'b0);
        throw_pins(4'd8, 1'b0, 1'b0, 10'd10, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sanitise_drain: %0d throws without AD, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_apd();
        apply_reset();
        throw_pins(4'd7, 1'b0, 1'b1, 10'd7, 1'b1, 1'b1, 1'b0);
        throw_pins(4'd2, 1'b0, 1'b0, BONUS ? 10'd11 : 10'd9,  1'b0, 1'b0, 1'b0);
        throw_pins(4'd3, 1'b0, 1'b1, BONUS ? 10'd17 : 10'd12, 1'b1, 1'b1, 1'b0);
        throw_pins(4'd1, 1'b0, 1'b0, BONUS ? 10'd19 : 10'd13, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL apd_drain: %0d throws without AD, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1; upd = 1'b0; APD = 1'b0; LF = 1'b0; N = 4'd0;
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_game();
        test_perfect();
        test_tenth_frame();
        test_held_upd();
        test_sanitise_and_reset();
        test_apd();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
